// File: rtl/cpu_pkg.sv
// Shared definitions for the 4-bit accumulator CPU: default widths, arbitration
// modes and the instruction opcodes used by the host loader and benches.
package cpu_pkg;

    localparam int ADDR_W_DEF = 4;
    localparam int DATA_W_DEF = 4;

    localparam logic PRIO_RR   = 1'b0;
    localparam logic PRIO_HOST = 1'b1;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_LOAD  = 4'd1,
        OP_ADD   = 4'd2,
        OP_SUB   = 4'd3,
        OP_AND   = 4'd4,
        OP_OR    = 4'd5,
        OP_STORE = 4'd6,
        OP_JMP   = 4'd7
    } opcode_e;

endpackage

// File: rtl/cpu_mem_arbiter_rr_arb2.sv
// Two-requester arbiter: round-robin with a one-bit pointer, or fixed priority
// to requester 1. Grants are combinational and forced low during reset.
module rr_arb2
    import cpu_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic mode_i,
    input  logic req0_i,
    input  logic req1_i,
    output logic gnt0_o,
    output logic gnt1_o
);

    // ptr_q = 0 means requester 0 wins the next contended cycle
    logic ptr_q, ptr_d;
    logic gnt0_d, gnt1_d;

    always_comb begin
        gnt0_d = 1'b0;
        gnt1_d = 1'b0;
        ptr_d  = ptr_q;
        if (!reset) begin
            if (req0_i && req1_i) begin
                if (mode_i == PRIO_HOST || ptr_q) begin
                    gnt1_d = 1'b1;
                end else begin
                    gnt0_d = 1'b1;
                end
            end else begin
                gnt0_d = req0_i;
                gnt1_d = req1_i;
            end
            if (gnt0_d) begin
                ptr_d = 1'b1;
            end else if (gnt1_d) begin
                ptr_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign gnt0_o = gnt0_d;
    assign gnt1_o = gnt1_d;

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Program/data memory shared by the CPU core (port 0) and the host loader
// (port 1): one access per clock, registered read data, saturating conflict count.
module cpu_mem_arbiter
    import cpu_pkg::*;
#(
    parameter int   ADDR_W    = ADDR_W_DEF,
    parameter int   DATA_W    = DATA_W_DEF,
    parameter logic PRIO_MODE = PRIO_RR,
    parameter int   CNT_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic [CNT_W-1:0]  conflict_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              wr_en, rd_en;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .mode_i (PRIO_MODE),
        .req0_i (req0),
        .req1_i (req1),
        .gnt0_o (gnt0),
        .gnt1_o (gnt1)
    );

    // At most one grant is high, so the granted port's request drives the array
    always_comb begin
        wr_en     = 1'b0;
        rd_en     = 1'b0;
        acc_addr  = addr0;
        acc_wdata = wdata0;
        if (gnt1) begin
            wr_en     = we1;
            rd_en     = !we1;
            acc_addr  = addr1;
            acc_wdata = wdata1;
        end else if (gnt0) begin
            wr_en = we0;
            rd_en = !we0;
        end
    end

    // Per-word registers so the whole array can be cleared by reset
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
            always_ff @(posedge clk) begin
                if (reset) begin
                    mem_q[gi] <= '0;
                end else if (wr_en && acc_addr == ADDR_W'(gi)) begin
                    mem_q[gi] <= acc_wdata;
                end
            end
        end
    endgenerate

    always_comb begin
        rdata_d   = rdata_q;
        rvalid0_d = gnt0 && !we0;
        rvalid1_d = gnt1 && !we1;
        cnt_d     = cnt_q;
        if (rd_en) begin
            rdata_d = mem_q[acc_addr];
        end
        if (req0 && req1 && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata_q   <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            rdata_q   <= rdata_d;
            rvalid0_q <= rvalid0_d;
            rvalid1_q <= rvalid1_d;
            cnt_q     <= cnt_d;
        end
    end

    assign rdata        = rdata_q;
    assign rvalid0      = rvalid0_q;
    assign rvalid1      = rvalid1_q;
    assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Self-checking bench: a round-robin instance carries most scenarios, a
// fixed-priority instance checks host-wins arbitration. Reads are scoreboarded.
module tb_cpu_mem_arbiter;
    import cpu_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, we0, req1, we1;
    logic [3:0] addr0, wdata0, addr1, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1;
    logic [3:0] rdata;
    logic [7:0] conflict_cnt;

    logic       f_req0, f_we0, f_req1, f_we1;
    logic [3:0] f_addr0, f_wdata0, f_addr1, f_wdata1;
    logic       f_gnt0, f_gnt1, f_rvalid0, f_rvalid1;
    logic [3:0] f_rdata;
    logic [7:0] f_conflict_cnt;

    typedef struct {
        bit         port;
        logic [3:0] data;
    } exp_t;

    exp_t       sb_q[$];
    exp_t       mon_exp;
    logic [3:0] model_mem [16];
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    cpu_mem_arbiter #(.ADDR_W(4), .DATA_W(4), .PRIO_MODE(1'b0), .CNT_W(8)) u_rr (
        .clk(clk), .reset(reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1), .rvalid1(rvalid1),
        .rdata(rdata), .conflict_cnt(conflict_cnt)
    );

    cpu_mem_arbiter #(.ADDR_W(4), .DATA_W(4), .PRIO_MODE(1'b1), .CNT_W(8)) u_fp (
        .clk(clk), .reset(reset),
        .req0(f_req0), .we0(f_we0), .addr0(f_addr0), .wdata0(f_wdata0), .gnt0(f_gnt0), .rvalid0(f_rvalid0),
        .req1(f_req1), .we1(f_we1), .addr1(f_addr1), .wdata1(f_wdata1), .gnt1(f_gnt1), .rvalid1(f_rvalid1),
        .rdata(f_rdata), .conflict_cnt(f_conflict_cnt)
    );

    // Read-result monitor: every rvalid pulse must match the oldest expected read
    always @(negedge clk) begin
        if (rvalid0 === 1'b1 || rvalid1 === 1'b1) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_rvalid got rvalid0=%b rvalid1=%b expected none", rvalid0, rvalid1);
            end else begin
                mon_exp = sb_q.pop_front();
                if (rvalid0 !== !mon_exp.port || rvalid1 !== mon_exp.port || rdata !== mon_exp.data) begin
                    n_fail++;
                    $display("FAIL sb_read got rv0=%b rv1=%b rdata=%h expected port%0d rdata=%h",
                             rvalid0, rvalid1, rdata, mon_exp.port, mon_exp.data);
                end else begin
                    $display("read  port%0d rdata=%h ok", mon_exp.port, rdata);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
        f_req0 = 0; f_we0 = 0; f_addr0 = 0; f_wdata0 = 0;
        f_req1 = 0; f_we1 = 0; f_addr1 = 0; f_wdata1 = 0;
    endtask

    task automatic apply_reset(input int cycles);
        reset = 1'b1;
        for (int i = 0; i < 16; i++) model_mem[i] = 4'h0;
        repeat (cycles) step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_all();
        reset = 1'b1;
        req0 = 1; req1 = 1; f_req0 = 1; f_req1 = 1;
        for (int i = 0; i < 16; i++) model_mem[i] = 4'h0;
        for (int c = 0; c < 2; c++) begin
            #1;
            n_checks++;
            if ({gnt0, gnt1, f_gnt0, f_gnt1} !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_gnt got %b expected 0000", {gnt0, gnt1, f_gnt0, f_gnt1});
            end
            step();
        end
        reset = 1'b0;
        idle_all();
        req1 = 1; we1 = 0; addr1 = 4'd5;
        #1;
        n_checks++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_gnt got gnt0=%b gnt1=%b expected 0 1", gnt0, gnt1);
        end
        sb_q.push_back('{port: 1'b1, data: model_mem[5]});
        step();
        req1 = 0;
        n_checks++;
        if (rvalid1 !== 1'b1 || rdata !== 4'h0 || conflict_cnt !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_first_read got rv1=%b rdata=%h cnt=%0d expected 1 0 0", rvalid1, rdata, conflict_cnt);
        end
        $display("reset test done");
    endtask

    task automatic test_load_fetch();
        req1 = 1; we1 = 1; addr1 = 4'd2; wdata1 = OP_SUB;
        #1;
        n_checks++;
        if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
            n_fail++;
            $display("FAIL load_gnt1 got gnt0=%b gnt1=%b expected 0 1", gnt0, gnt1);
        end
        model_mem[2] = OP_SUB;
        step();
        req1 = 0; we1 = 0;
        req0 = 1; we0 = 0; addr0 = 4'd2;
        #1;
        n_checks++;
        if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
            n_fail++;
            $display("FAIL fetch_gnt0 got gnt0=%b gnt1=%b expected 1 0", gnt0, gnt1);
        end
        sb_q.push_back('{port: 1'b0, data: model_mem[2]});
        step();
        req0 = 0;
        n_checks++;
        if (rvalid0 !== 1'b1 || rvalid1 !== 1'b0 || rdata !== 4'b0011) begin
            n_fail++;
            $display("FAIL fetch_read got rv0=%b rv1=%b rdata=%h expected 1 0 3", rvalid0, rvalid1, rdata);
        end
        $display("load/fetch addr2 done");
    endtask

    task automatic test_rr_contention();
        idle_all();
        apply_reset(1);
        req0 = 1; we0 = 1; addr0 = 4'd8; wdata0 = OP_LOAD;
        req1 = 1; we1 = 1; addr1 = 4'd9; wdata1 = OP_JMP;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (gnt0 !== (i % 2 == 0) || gnt1 !== (i % 2 == 1)) begin
                n_fail++;
                $display("FAIL rr_grant cycle %0d got gnt0=%b gnt1=%b expected port%0d", i, gnt0, gnt1, i % 2);
            end else begin
                $display("rr cycle %0d granted port%0d", i, i % 2);
            end
            step();
        end
        if (1) begin
            model_mem[8] = OP_LOAD;
            model_mem[9] = OP_JMP;
        end
        idle_all();
        n_checks++;
        if (conflict_cnt !== 8'd4) begin
            n_fail++;
            $display("FAIL rr_conflict_cnt got %0d expected 4", conflict_cnt);
        end
        // both writes landed: read them back through the scoreboard
        req0 = 1; we0 = 0; addr0 = 4'd9;
        sb_q.push_back('{port: 1'b0, data: model_mem[9]});
        step();
        req0 = 0;
        req1 = 1; we1 = 0; addr1 = 4'd8;
        sb_q.push_back('{port: 1'b1, data: model_mem[8]});
        step();
        req1 = 0;
        step();
    endtask

    task automatic test_fixed_priority();
        f_req0 = 1; f_we0 = 1; f_addr0 = 4'd3; f_wdata0 = OP_ADD;
        f_req1 = 1; f_we1 = 1; f_addr1 = 4'd4; f_wdata1 = OP_OR;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) f_req1 = 0;
            #1;
            n_checks++;
            if (f_gnt0 !== (i == 3) || f_gnt1 !== (i < 3)) begin
                n_fail++;
                $display("FAIL fp_grant cycle %0d got gnt0=%b gnt1=%b", i, f_gnt0, f_gnt1);
            end else begin
                $display("fp cycle %0d granted port%0d", i, (i == 3) ? 0 : 1);
            end
            step();
        end
        f_req0 = 0;
        n_checks++;
        if (f_conflict_cnt !== 8'd3 || f_rvalid0 !== 1'b0 || f_rvalid1 !== 1'b0) begin
            n_fail++;
            $display("FAIL fp_conflict_cnt got cnt=%0d rv=%b%b expected 3 00", f_conflict_cnt, f_rvalid0, f_rvalid1);
        end
    endtask

    task automatic test_boundary();
        req1 = 1; we1 = 1; addr1 = 4'd15; wdata1 = 4'b1110;
        model_mem[15] = 4'b1110;
        step();
        req1 = 0; we1 = 0;
        req0 = 1; we0 = 0; addr0 = 4'd15;
        sb_q.push_back('{port: 1'b0, data: model_mem[15]});
        step();
        req0 = 0;
        n_checks++;
        if (rdata !== 4'b1110) begin
            n_fail++;
            $display("FAIL addr15_read got %h expected e", rdata);
        end
        step();
        apply_reset(1);
        req0 = 1; we0 = 1; addr0 = 4'd13; wdata0 = 4'd1;
        req1 = 1; we1 = 1; addr1 = 4'd14; wdata1 = 4'd2;
        repeat (254) step();
        n_checks++;
        if (conflict_cnt !== 8'd254) begin
            n_fail++;
            $display("FAIL cnt_254 got %0d expected 254", conflict_cnt);
        end
        step();
        n_checks++;
        if (conflict_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL cnt_255 got %0d expected 255", conflict_cnt);
        end
        repeat (45) step();
        idle_all();
        n_checks++;
        if (conflict_cnt !== 8'd255) begin
            n_fail++;
            $display("FAIL cnt_saturate got %0d expected 255", conflict_cnt);
        end
        $display("conflict counter after 300 contention cycles = %0d", conflict_cnt);
        model_mem[13] = 4'd1;
        model_mem[14] = 4'd2;
    endtask

    task automatic test_reset_mid_read();
        req1 = 1; we1 = 1; addr1 = 4'd2; wdata1 = OP_STORE;
        model_mem[2] = OP_STORE;
        step();
        idle_all();
        req0 = 1; we0 = 0; addr0 = 4'd2;
        #1;
        n_checks++;
        if (gnt0 !== 1'b1) begin
            n_fail++;
            $display("FAIL midread_gnt0 got %b expected 1", gnt0);
        end
        sb_q.push_back('{port: 1'b0, data: model_mem[2]});
        step();
        req0 = 0;
        apply_reset(1);
        n_checks++;
        if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || rdata !== 4'h0) begin
            n_fail++;
            $display("FAIL midread_after_reset got rv0=%b rv1=%b rdata=%h expected 0 0 0", rvalid0, rvalid1, rdata);
        end
        req0 = 1; we0 = 0; addr0 = 4'd2;
        sb_q.push_back('{port: 1'b0, data: model_mem[2]});
        step();
        req0 = 0;
        n_checks++;
        if (rdata !== 4'h0) begin
            n_fail++;
            $display("FAIL midread_cleared got %h expected 0", rdata);
        end
        step();
    endtask

    initial begin
        reset = 1'b1;
        idle_all();
        test_reset();
        test_load_fetch();
        test_rr_contention();
        test_fixed_priority();
        test_boundary();
        test_reset_mid_read();
        step();
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain got %0d pending reads expected 0", sb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
- Owns the 16x4 program/data memory used by the 4-bit accumulator CPU.
- Shares that memory between two requesters: port 0 is the CPU core (fetch, operand, STORE); port 1 is the host/debug loader (program load, memory inspection).
- Performs one access per clock, selected by a round-robin or fixed-priority arbiter.
- Provides registered read data and a saturating conflict counter for performance debug.

Parameters:
- ADDR_W, 4, address width; memory depth is 2**ADDR_W words.
- DATA_W, 4, word width; matches the CPU opcode/operand width.
- PRIO_MODE, 0, 0 = round-robin; 1 = fixed priority to port 1 (host wins).
- CNT_W, 8, conflict counter width.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- req0  in  1  CPU access request
- we0  in  1  CPU write enable (1 = write, 0 = read)
- addr0  in  ADDR_W  CPU address
- wdata0  in  DATA_W  CPU write data
- gnt0  out  1  CPU access performed this cycle
- rvalid0  out  1  rdata holds CPU read result
- req1  in  1  host access request
- we1  in  1  host write enable
- addr1  in  ADDR_W  host address
- wdata1  in  DATA_W  host write data
- gnt1  out  1  host access performed this cycle
- rvalid1  out  1  rdata holds host read result
- rdata  out  DATA_W  registered read data, shared by both ports
- conflict_cnt  out  CNT_W  count of cycles with req0 && req1, saturating

Behaviour:
- Reset (clk edge with reset=1):
  - all memory words cleared to 0;
  - rvalid0, rvalid1, rdata and conflict_cnt cleared to 0;
  - round-robin pointer set to "port 0 next".
  - Reset has priority over every other event.
  - Reset arriving mid-operation cancels any pending read: no rvalid pulse follows.
- gnt0/gnt1 are combinational from req*, PRIO_MODE, the pointer and reset.
  - Both are 0 while reset=1.
  - At most one grant is high in any cycle.
- Handshake:
  - A requester holds req, we, addr and wdata stable until it sees gnt high.
  - The access completes at the rising edge where gnt=1.
  - The requester may drop req or present a new request in the next cycle.
- Arbitration:
  - Only one request active: that port is granted the same cycle.
  - Both active, PRIO_MODE=0: grant goes to the port indicated by the pointer.
  - Both active, PRIO_MODE=1: port 1 is always granted; port 0 waits indefinitely.
  - Pointer update: after any grant, the pointer points at the other port. It is unchanged when there is no grant.
  - Worst-case wait in round-robin mode is 1 cycle.
- Write: when granted with we=1, mem[addr] <= wdata at that edge. rvalid is not asserted for writes.
- Read: when granted with we=0, rdata <= mem[addr] at that edge.
  - rvalidN is high for exactly the following cycle: latency 1.
  - rdata holds its value until the next granted read.
  - rvalid of the non-granted port is 0.
- Read-after-write:
  - A write granted at edge N followed by a read of the same address granted at edge N+1 returns the new data. No bypass is needed.
  - Within one cycle only one access exists, so there is no same-cycle read/write hazard.
- Address wrap: addresses are exactly ADDR_W bits; address 15 is valid, and there is no out-of-range case.
- conflict_cnt:
  - increments at each non-reset edge where req0 && req1;
  - saturates at 2**CNT_W-1;
  - does not wrap.

Decomposition:
- Shared package cpu_pkg:
  - ADDR_W/DATA_W defaults;
  - PRIO_RR/PRIO_HOST constants;
  - CPU opcode constants (NOP=0, LOAD=1, ADD=2, SUB=3, AND=4, OR=5, STORE=6, JMP=7), used by the host loader and the benches.
- One natural sub-module, rr_arb2: 2-input arbiter with pointer register, mode input and grant outputs.
- The memory array, read register and counter stay in the top level.

Test Plan:
- Reset check: assert reset 2 cycles, then req1=1, we1=0, addr1=5 -> gnt1=1; next cycle rvalid1=1, rdata=0; conflict_cnt=0; gnt0=gnt1=0 throughout reset.
- Load then fetch:
  - host writes addr2=4'b0011 (gnt1 same cycle);
  - next cycle CPU reads addr2 -> gnt0=1;
  - following cycle rvalid0=1, rvalid1=0, rdata=4'b0011.
- Round-robin contention: PRIO_MODE=0, req0=req1=1 held 4 cycles right after reset -> grants 0,1,0,1; conflict_cnt=4.
- Fixed priority: PRIO_MODE=1, req0=req1=1 for 3 cycles, then req1=0 -> gnt1 for 3 cycles, gnt0 on the 4th; conflict_cnt=3.
- Boundary:
  - host writes addr15=4'b1110, CPU reads addr15 -> rdata=4'b1110;
  - 300 consecutive contention cycles -> conflict_cnt=255, stays 255.
- Reset mid-read: CPU read of addr2 granted at edge N, reset=1 at edge N+1 -> rvalid0=0 after edge N+1; subsequent read of addr2 returns 0.
